// File: rtl/ram_sync_clr_pkg.sv
// rtl/ram_sync_clr_pkg.sv - shared types and helpers for the clearable synchronous RAM
package ram_sync_clr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Number of byte-enable lanes in a word.
    function automatic int num_lanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - read-data/valid register chain setting the read latency
module ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]    vld;
    logic [DATA_WIDTH-1:0] dat [LATENCY];

    // Shift valid every cycle; data stages load only behind a valid, so the
    // output word holds between read pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[LATENCY-1];
    assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/ram_sync_clr.sv
// rtl/ram_sync_clr.sv - byte-enabled synchronous RAM with full-array clear sweep
module ram_sync_clr
    import ram_sync_clr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8,
    parameter int DEPTH_LOG2 = 9,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 1,
    localparam int NUM_LANES = num_lanes(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_LANES-1:0]  wr_be,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    state_t                state, state_nxt;
    logic [DEPTH_LOG2-1:0] sweep_addr, sweep_addr_nxt;

    logic                  idle;
    logic                  rd_accept;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_LANES-1:0]  mem_be;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_merged;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // State and sweep pointer; reset lands in CLEAR so the array is always
    // zeroed before first use.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR;
            sweep_addr <= '0;
        end else begin
            state      <= state_nxt;
            sweep_addr <= sweep_addr_nxt;
        end
    end

    // Next state: clear starts a sweep from IDLE only; the sweep ends after
    // the last address is written.
    always_comb begin
        state_nxt      = state;
        sweep_addr_nxt = sweep_addr;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt      = CLEAR;
                    sweep_addr_nxt = '0;
                end
            end
            CLEAR: begin
                sweep_addr_nxt = sweep_addr + 1'b1;
                if (&sweep_addr) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign busy      = (state == CLEAR);
    assign idle      = (state == IDLE);
    assign rd_accept = idle && rd_en;

    // Single write port shared by the sweep and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_be    = wr_be;
        if (busy) begin
            mem_we    = 1'b1;
            mem_addr  = sweep_addr;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (wr_en) begin
            mem_we = 1'b1;
        end
    end

    // Lane-masked synchronous write; no reset on the array itself.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (mem_be[l]) begin
                    mem[mem_addr][l*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    assign rd_word = mem[rd_addr];

    // Same-address collision: optionally forward the enabled write lanes.
    always_comb begin
        rd_merged = rd_word;
        if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr)) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wr_be[l]) begin
                    rd_merged[l*LANE_WIDTH +: LANE_WIDTH] = wr_data[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_accept),
        .in_data   (rd_merged),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

// File: doc/ram_sync_clr.md
RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; must be a multiple of LANE_WIDTH.
REQ-002 SHALL have parameter LANE_WIDTH, default 8: byte-enable lane width; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
REQ-003 SHALL have parameter DEPTH_LOG2, default 9: address width; DEPTH = 2**DEPTH_LOG2.
REQ-004 SHALL have parameter RD_LATENCY, default 1: legal values 1 or 2 cycles from rd_en to rd_valid.
REQ-005 SHALL have parameter BYPASS, default 1: read/write same-address collision policy.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 clear  input  1  single-cycle request to zero the entire array.
REQ-009 busy  output  1  high while the clear sweep runs.
REQ-010 wr_en  input  1  write strobe.
REQ-011 wr_addr  input  DEPTH_LOG2  write address.
REQ-012 wr_data  input  DATA_WIDTH  write data.
REQ-013 wr_be  input  NUM_LANES  per-lane write enable; bit i covers wr_data[i*LANE_WIDTH +: LANE_WIDTH].
REQ-014 rd_en  input  1  read request.
REQ-015 rd_addr  input  DEPTH_LOG2  read address.
REQ-016 rd_data  output  DATA_WIDTH  registered read data.
REQ-017 rd_valid  output  1  rd_data qualifier, single-cycle pulse per accepted read.

Function
REQ-018 FSM SHALL have two states: IDLE and CLEAR.
REQ-019 CLEAR SHALL write all-zero words to addresses 0..DEPTH-1, one per cycle, ascending; it returns to IDLE the cycle after address DEPTH-1 is written (sweep = DEPTH cycles).
REQ-020 busy SHALL equal (state == CLEAR).
REQ-021 clear asserted in IDLE SHALL enter CLEAR on the next edge with sweep counter 0; clear asserted in CLEAR SHALL be ignored (no restart).
REQ-022 In IDLE, wr_en SHALL update only those lanes of mem[wr_addr] whose wr_be bit is 1; wr_be = 0 SHALL leave memory unchanged.
REQ-023 While busy, wr_en and rd_en SHALL be ignored: no memory update, no rd_valid.
REQ-024 A read accepted in IDLE SHALL assert rd_valid exactly RD_LATENCY cycles after the rd_en edge, with rd_data = addressed word.
REQ-025 Back-to-back reads SHALL be accepted every cycle; rd_valid pulses SHALL appear in request order, one per request.
REQ-026 Collision (rd_en and wr_en, rd_addr == wr_addr, same cycle): BYPASS=1 SHALL return the old word with enabled lanes replaced by wr_data; BYPASS=0 SHALL return the pre-write word.
REQ-027 rd_data SHALL hold its last value when rd_valid is low.
REQ-028 A read accepted on the last IDLE cycle before clear takes effect SHALL still complete; its data is the pre-clear content.
REQ-029 Write and read address SHALL be used unmodified (no wrap logic beyond DEPTH_LOG2 bits).

Reset
REQ-030 reset_n low SHALL asynchronously force state = CLEAR, sweep counter = 0, rd_valid = 0, rd_data = 0, read pipeline valid bits = 0.
REQ-031 busy SHALL therefore read 1 during and after reset until the DEPTH-cycle sweep completes.
REQ-032 Memory array SHALL NOT be asynchronously reset; zeroing is by the sweep only.
REQ-033 reset_n asserted mid-sweep SHALL restart the sweep from address 0 after release.

Structure
REQ-034 Shared package ram_sync_clr_pkg SHALL hold the state enum (IDLE, CLEAR) and a lane-count helper function.
REQ-035 The RD_LATENCY output stage SHALL be one sub-module, ram_rd_pipe (data + valid register chain, reset per REQ-030).
REQ-036 Storage SHALL be an inferred synchronous-write array with registered read, suitable for block RAM inference.

Verification (DATA_WIDTH=32, LANE_WIDTH=8, DEPTH_LOG2=4)
REQ-037 Release reset -> busy=1 for 16 cycles then 0; reads of all 16 addresses return 0x00000000.
REQ-038 Write 0xAABBCCDD to addr 3 with wr_be=4'b1111, then wr_be=4'b0101 data 0x11223344 -> read addr 3 returns 0xAA22CC44 after RD_LATENCY cycles.
REQ-039 Same-cycle write 0x12345678 (wr_be=1111) and read at addr 5 holding 0 -> BYPASS=1 returns 0x12345678, BYPASS=0 returns 0x00000000.
REQ-040 Reads of addrs 0,1,2 on consecutive cycles, RD_LATENCY=2 -> three consecutive rd_valid pulses starting 2 cycles after first rd_en, data in order.
REQ-041 clear pulse, then wr_en at addr 7 and rd_en during busy -> no rd_valid, addr 7 reads 0 after sweep; second clear pulse mid-sweep does not extend busy past 16 cycles.
REQ-042 reset_n pulsed low at sweep address 9 -> rd_valid=0, rd_data=0 immediately; busy lasts 16 full cycles after release.
